led_rgb_mux_driver: RTL and testbench
=====================================

# led_rgb_mux_driver

Scanned, PWM-dimmed driver for the 7×RGB multiplexed LED matrix on the ButterStick, directly downstream of the blink/counter logic in `top`. It replaces the raw counter bits on `led_rgb_multiplex_a` and `led_rgb_multiplex_b` with a time-multiplexed display. Per-LED 24-bit colour values are written into a shadow store over a valid/ready port. At every frame boundary the shadow store is copied atomically into the active store, so no partially updated frame is ever shown.

## Interface
Parameters:
- `N_LED`, 7: number of multiplexed LED positions; also the width of `led_rgb_multiplex_a`.
- `PWM_BITS`, 8: duty resolution per colour.
- `PRESCALE`, 15: clk30 cycles per PWM tick; must be ≥1. Gives a 2 MHz tick and a ≈1.12 kHz frame at the defaults.
- `BLANK`, 4: PWM ticks at the end of each slot with all outputs off (anti-ghosting). Must satisfy 0 ≤ `BLANK` < 2^`PWM_BITS`.
- `A_ACTIVE_LOW`, 0 and `B_ACTIVE_LOW`, 0: output polarity of the `a` and `b` lines.

Ports:
- `clk30`, input, 1: the single 30 MHz clock.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `wr_valid`, input, 1: write request.
- `wr_ready`, output, 1: write accepted when `wr_valid` and `wr_ready` are both high on a rising clk30 edge.
- `wr_addr`, input, 3: LED index, 0..`N_LED`-1.
- `wr_data`, input, 3×`PWM_BITS`: duty values packed as {R, G, B}, with R in the MSBs.
- `led_rgb_multiplex_a`, output, `N_LED`: one-hot LED-position select.
- `led_rgb_multiplex_b`, output, 3: colour enables, bit 2 = R, bit 1 = G, bit 0 = B.
- `frame_start`, output, 1: one-cycle pulse in the cycle the active store is loaded.

## Operation
- **Prescaler** `pre` counts 0..`PRESCALE`-1 and wraps. `tick` is high when `pre`==`PRESCALE`-1.
- **On each `tick`:** `pwm_cnt` increments. When it wraps from 2^`PWM_BITS`-1 to 0, `slot` increments. When `slot` wraps from `N_LED`-1 to 0, the cycle is a frame boundary (`fb`).
- **Frame boundary:** active[i] ← shadow[i] for all i, and `frame_start` pulses for one cycle.
- **Writes:** an accepted write sets shadow[`wr_addr`] ← `wr_data`. A write with `wr_addr` ≥ `N_LED` is accepted and discarded.
- **`wr_ready`** is combinational and equals !`fb`. It is low only in the frame-boundary cycle, so a shadow write and the copy never coincide. A held `wr_valid` is accepted in the following cycle.
- **Visible window:** `vis` = (`pwm_cnt` < 2^`PWM_BITS`-`BLANK`).
- **Raw outputs:**
  - a_raw[i] = `vis` && (i == `slot`).
  - b_raw[c] = `vis` && (`pwm_cnt` < active[`slot`][c]).
  - Duty 0 is fully off. Duty ≥ 2^`PWM_BITS`-`BLANK` saturates at full visible-window on-time.
- **Polarity:** the registered outputs are a_raw XOR `A_ACTIVE_LOW` and b_raw XOR `B_ACTIVE_LOW`, applied bitwise.
- **Counters** are unsigned and wrap modulo their ranges. `slot` never takes values ≥ `N_LED`.

## Timing
- **Reset values (while `rst_n` is low):**
  - `pre`, `pwm_cnt`, `slot` = 0.
  - shadow and active stores = 0.
  - `frame_start` = 0.
  - `led_rgb_multiplex_a` and `led_rgb_multiplex_b` inactive (all-0 when active-high, all-1 when active-low).
  - `wr_ready` = 1.
- **Reset mid-operation** clears everything immediately and asynchronously. Outputs go inactive without waiting for a clock edge.
- **First frame after reset:** the first `fb` occurs after `N_LED`·2^`PWM_BITS`·`PRESCALE` cycles. Until then the display shows all-zero duty, i.e. dark.
- **Output latency:** `led_rgb_multiplex_*` are registered and lag the counter state by 1 cycle. `frame_start` is registered and asserts in the cycle after `fb`.
- **Write-to-display latency:** an accepted write appears from the first slot 0 after the next `fb`. Worst case is one frame plus one cycle.
- **Frame period:** exactly `N_LED`·2^`PWM_BITS`·`PRESCALE` cycles. The blanking window is `BLANK`·`PRESCALE` cycles at the end of each slot.

## Structure
- **Shared package `led_mux_pkg`:**
  - colour index constants `COL_R`=2, `COL_G`=1, `COL_B`=0;
  - an `rgb_duty_t` typedef (3×`PWM_BITS` packed);
  - the default `N_LED`/`PWM_BITS` values, for reuse by the future colour-pattern generator.
- **Sub-module `led_pwm_timebase`:** contains the prescaler, `pwm_cnt` and `slot` counters, and outputs `tick`, `pwm_cnt`, `slot`, `fb`, `vis`.
- **Top level:** holds the shadow/active stores, the write port and the output registers.

## Test plan
All scenarios use `PRESCALE`=1, `PWM_BITS`=4, `BLANK`=1, `N_LED`=7, active-high polarity unless noted.

- **Reset:** hold `rst_n`=0 for 5 cycles, then release → `a`=0, `b`=0, `wr_ready`=1. The first `frame_start` pulse appears 112+1 cycles after release.
- **Single LED:** write addr 3 = {R=15, G=8, B=0}, then wait for `frame_start` → during slot 3:
  - `a`=7'b0001000 for 15 of 16 cycles;
  - R on for 15 cycles, G on for 8 cycles, B never on;
  - all outputs 0 in the blank cycle.
- **Boundary collision:** hold `wr_valid` high across `fb` → `wr_ready`=0 exactly in that cycle; the write is accepted in the next cycle and displayed in the following frame, not the current one.
- **Out-of-range address:** write addr 7 = 0xFFF → accepted with no visible change on any slot.
- **Atomic update:** write all 7 LEDs mid-frame → the current frame still shows the old values; every slot of the next frame shows the new values.
- **Polarity and async reset:** with `A_ACTIVE_LOW`=1 and `B_ACTIVE_LOW`=1, assert `rst_n` low mid-slot → outputs go to all-1 before the next clk30 edge.

Source files
------------

// File: rtl/led_mux_pkg.sv
// +----------------------------------------------------------------------------+
// | led_mux_pkg                                                                |
// | Shared colour indices, duty type and default geometry for the LED mux.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package led_mux_pkg;

  localparam int COL_R = 2;
  localparam int COL_G = 1;
  localparam int COL_B = 0;

  localparam int DEF_N_LED    = 7;
  localparam int DEF_PWM_BITS = 8;

  typedef logic [3*DEF_PWM_BITS-1:0] rgb_duty_t;

endpackage

`default_nettype wire

// File: rtl/led_pwm_timebase.sv
// +----------------------------------------------------------------------------+
// | led_pwm_timebase                                                           |
// | Prescaler, PWM counter and slot counter with frame-boundary strobe.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module led_pwm_timebase
  import led_mux_pkg::*;
#(
  parameter int N_LED    = DEF_N_LED,
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int PRESCALE = 15,
  parameter int BLANK    = 4,
  localparam int SLOT_W  = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic                clk30,
  input  logic                rst_n,
  output logic                tick,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic [SLOT_W-1:0]   slot,
  output logic                fb,
  output logic                vis
);

  localparam int                PRE_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  c_pre_last  = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] c_pwm_last = '1;
  localparam logic [SLOT_W-1:0] c_slot_last = SLOT_W'(N_LED - 1);
  localparam logic [PWM_BITS:0] c_vis_lim   = (PWM_BITS+1)'((1 << PWM_BITS) - BLANK);

  logic [PRE_W-1:0]    r_pre;
  logic [PWM_BITS-1:0] r_pwm;
  logic [SLOT_W-1:0]   r_slot;

  assign tick    = (r_pre == c_pre_last);
  assign fb      = tick && (r_pwm == c_pwm_last) && (r_slot == c_slot_last);
  assign vis     = ({1'b0, r_pwm} < c_vis_lim);
  assign pwm_cnt = r_pwm;
  assign slot    = r_slot;

  always_ff @(posedge clk30 or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_pwm  <= '0;
      r_slot <= '0;
    end else begin
      r_pre <= tick ? '0 : r_pre + 1'b1;
      if (tick) begin
        r_pwm <= r_pwm + 1'b1;
        // slot is bounded explicitly so it never reaches N_LED
        if (r_pwm == c_pwm_last) begin
          r_slot <= (r_slot == c_slot_last) ? '0 : r_slot + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_rgb_mux_driver.sv
// +----------------------------------------------------------------------------+
// | led_rgb_mux_driver                                                         |
// | Scanned, PWM-dimmed RGB matrix driver with double-buffered colour store.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module led_rgb_mux_driver
  import led_mux_pkg::*;
#(
  parameter int N_LED        = DEF_N_LED,
  parameter int PWM_BITS     = DEF_PWM_BITS,
  parameter int PRESCALE     = 15,
  parameter int BLANK        = 4,
  parameter int A_ACTIVE_LOW = 0,
  parameter int B_ACTIVE_LOW = 0
) (
  input  logic                  clk30,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2:0]            wr_addr,
  input  logic [3*PWM_BITS-1:0] wr_data,
  output logic [N_LED-1:0]      led_rgb_multiplex_a,
  output logic [2:0]            led_rgb_multiplex_b,
  output logic                  frame_start
);

  localparam int                 SLOT_W    = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam logic [N_LED-1:0]   c_a_inact = (A_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [2:0]         c_b_inact = (B_ACTIVE_LOW != 0) ? '1 : '0;

  logic                  w_tick;
  logic [PWM_BITS-1:0]   w_pwm;
  logic [SLOT_W-1:0]     w_slot;
  logic                  w_fb;
  logic                  w_vis;
  logic                  w_copy;
  logic                  w_we;
  logic [3*PWM_BITS-1:0] w_duty;
  logic [N_LED-1:0]      w_a_raw;
  logic [2:0]            w_b_raw;

  logic [3*PWM_BITS-1:0] r_shadow [N_LED];
  logic [3*PWM_BITS-1:0] r_active [N_LED];

  led_pwm_timebase #(
    .N_LED    (N_LED),
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE),
    .BLANK    (BLANK)
  ) u_timebase (
    .clk30   (clk30),
    .rst_n   (rst_n),
    .tick    (w_tick),
    .pwm_cnt (w_pwm),
    .slot    (w_slot),
    .fb      (w_fb),
    .vis     (w_vis)
  );

  // Blocking writes during the copy cycle keeps shadow and active coherent.
  assign wr_ready = !w_fb;
  assign w_copy   = w_tick && w_fb;
  assign w_we     = wr_valid && wr_ready && (32'(wr_addr) < N_LED);
  assign w_duty   = r_active[w_slot];

  always_ff @(posedge clk30 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LED; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_LED; i++) begin
        if (w_we && (32'(wr_addr) == i)) r_shadow[i] <= wr_data;
        if (w_copy)                      r_active[i] <= r_shadow[i];
      end
    end
  end

  always_comb begin
    w_a_raw = '0;
    w_b_raw = '0;
    for (int i = 0; i < N_LED; i++) begin
      w_a_raw[i] = w_vis && (32'(w_slot) == i);
    end
    w_b_raw[COL_R] = w_vis && (w_pwm < w_duty[COL_R*PWM_BITS +: PWM_BITS]);
    w_b_raw[COL_G] = w_vis && (w_pwm < w_duty[COL_G*PWM_BITS +: PWM_BITS]);
    w_b_raw[COL_B] = w_vis && (w_pwm < w_duty[COL_B*PWM_BITS +: PWM_BITS]);
  end

  // The inactive level doubles as the polarity mask.
  always_ff @(posedge clk30 or negedge rst_n) begin
    if (!rst_n) begin
      led_rgb_multiplex_a <= c_a_inact;
      led_rgb_multiplex_b <= c_b_inact;
      frame_start         <= 1'b0;
    end else begin
      led_rgb_multiplex_a <= w_a_raw ^ c_a_inact;
      led_rgb_multiplex_b <= w_b_raw ^ c_b_inact;
      frame_start         <= w_copy;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_rgb_mux_driver.sv
// +----------------------------------------------------------------------------+
// | tb_led_rgb_mux_driver                                                      |
// | Directed bench: PRESCALE=1, PWM_BITS=4, BLANK=1, N_LED=7 (112-cycle frame).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_led_rgb_mux_driver;

  logic clk30 = 1'b0;
  always #5 clk30 = ~clk30;

  logic        rst_n, wr_valid, wr_ready, frame_start;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data;
  logic [6:0]  a;
  logic [2:0]  b;

  logic        rst_n2, wr_ready2, frame_start2;
  logic [6:0]  a2;
  logic [2:0]  b2;

  led_rgb_mux_driver #(
    .N_LED(7), .PWM_BITS(4), .PRESCALE(1), .BLANK(1), .A_ACTIVE_LOW(0), .B_ACTIVE_LOW(0)
  ) dut (
    .clk30(clk30), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .led_rgb_multiplex_a(a),
    .led_rgb_multiplex_b(b), .frame_start(frame_start)
  );

  led_rgb_mux_driver #(
    .N_LED(7), .PWM_BITS(4), .PRESCALE(1), .BLANK(1), .A_ACTIVE_LOW(1), .B_ACTIVE_LOW(1)
  ) dut_inv (
    .clk30(clk30), .rst_n(rst_n2), .wr_valid(1'b0), .wr_ready(wr_ready2),
    .wr_addr(3'd0), .wr_data(12'h000), .led_rgb_multiplex_a(a2),
    .led_rgb_multiplex_b(b2), .frame_start(frame_start2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int exp_r [7];
  int exp_g [7];
  int exp_b [7];

  int          q_addr [$];
  logic [11:0] q_data [$];

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // On-time in one slot: duty clipped to the 15-tick visible window.
  function automatic int on_time(input int d);
    return (d > 15) ? 15 : d;
  endfunction

  task automatic set_led(input int s, input int r, input int g, input int bb);
    exp_r[s] = on_time(r);
    exp_g[s] = on_time(g);
    exp_b[s] = on_time(bb);
  endtask

  task automatic queue_wr(input int addr, input int r, input int g, input int bb);
    q_addr.push_back(addr);
    q_data.push_back({4'(r), 4'(g), 4'(bb)});
  endtask

  // Called right after frame_start is seen; observes the full 112-cycle frame.
  task automatic run_frame(input string name, input int wr_start);
    int a_on [7] = '{default: 0};
    int r_on [7] = '{default: 0};
    int g_on [7] = '{default: 0};
    int b_on [7] = '{default: 0};
    int a_bad = 0, blank_bad = 0, fs_hi = 0, rdy_low_n = 0, rdy_low_at = -1;
    int st, s, p;
    logic rdy;
    for (int j = 1; j <= 112; j++) begin
      st = j - 1;
      if (st >= wr_start && q_addr.size() > 0) begin
        wr_valid = 1'b1;
        wr_addr  = 3'(q_addr[0]);
        wr_data  = q_data[0];
      end else begin
        wr_valid = 1'b0;
      end
      rdy = wr_ready;
      if (!rdy) begin
        rdy_low_n++;
        rdy_low_at = st;
      end
      @(posedge clk30); #1;
      if (wr_valid && rdy) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      s = st / 16;
      p = st % 16;
      if (p < 15) begin
        if (a == 7'(1 << s)) a_on[s]++;
        else a_bad++;
      end else if (a != 7'd0 || b != 3'd0) begin
        blank_bad++;
      end
      r_on[s] += int'(b[2]);
      g_on[s] += int'(b[1]);
      b_on[s] += int'(b[0]);
      if (j < 112 && frame_start) fs_hi++;
    end
    for (int k = 0; k < 7; k++) begin
      check($sformatf("%s a_on[%0d]", name, k), a_on[k], 15);
      check($sformatf("%s r_on[%0d]", name, k), r_on[k], exp_r[k]);
      check($sformatf("%s g_on[%0d]", name, k), g_on[k], exp_g[k]);
      check($sformatf("%s b_on[%0d]", name, k), b_on[k], exp_b[k]);
    end
    check({name, " a_bad"}, a_bad, 0);
    check({name, " blank_bad"}, blank_bad, 0);
    check({name, " early_frame_start"}, fs_hi, 0);
    check({name, " ready_low_count"}, rdy_low_n, 1);
    check({name, " ready_low_at"}, rdy_low_at, 111);
    check({name, " frame_start_at_period"}, int'(frame_start), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, dark;
    rst_n    = 1'b0;
    rst_n2   = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 12'h000;
    for (int i = 0; i < 7; i++) set_led(i, 0, 0, 0);

    repeat (5) @(posedge clk30);
    #1;
    check("reset a", int'(a), 0);
    check("reset b", int'(b), 0);
    check("reset wr_ready", int'(wr_ready), 1);
    check("reset frame_start", int'(frame_start), 0);
    check("reset inv a", int'(a2), 7'h7F);
    check("reset inv b", int'(b2), 3'h7);
    rst_n = 1'b1;

    k    = 0;
    dark = 0;
    while (k < 400) begin
      @(posedge clk30); #1;
      k++;
      if (b != 3'd0) dark++;
      if (frame_start) break;
    end
    check("first frame_start cycle", k, 112);
    check("dark before first frame", dark, 0);

    queue_wr(3, 15, 8, 0);
    run_frame("f1_old", 0);

    set_led(3, 15, 8, 0);
    queue_wr(7, 15, 15, 15);
    run_frame("f2_single", 0);
    check("oor write accepted", q_addr.size(), 0);

    for (int i = 0; i < 7; i++) queue_wr(i, i, i + 8, 15 - 2 * i);
    run_frame("f3_atomic_old", 40);
    check("atomic writes drained", q_addr.size(), 0);

    for (int i = 0; i < 7; i++) set_led(i, i, i + 8, 15 - 2 * i);
    queue_wr(0, 0, 15, 0);
    run_frame("f4_atomic_new", 111);
    check("collision write held over fb", q_addr.size(), 1);

    run_frame("f5_collision_not_yet", 0);
    check("collision write accepted", q_addr.size(), 0);

    set_led(0, 0, 15, 0);
    run_frame("f6_collision_shown", 0);
    wr_valid = 1'b0;

    rst_n2 = 1'b1;
    repeat (3) @(posedge clk30);
    #1;
    check("inv slot0 a", int'(a2), 7'h7E);
    check("inv slot0 b", int'(b2), 3'h7);
    #3;
    rst_n2 = 1'b0;
    #1;
    check("inv async reset a", int'(a2), 7'h7F);
    check("inv async reset b", int'(b2), 3'h7);
    check("inv async reset wr_ready", int'(wr_ready2), 1);
    check("inv async reset frame_start", int'(frame_start2), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
